// File: rtl/sram_ctrl_if.sv
// CPU-side byte bus between the system bus decode and the SRAM controller.
`timescale 1ns/1ps
interface sram_ctrl_if #(
    parameter int ADDR_W = 16
) ();
    logic              cs;
    logic [ADDR_W-1:0] addr;
    logic              rd_req;
    logic              wr_en;
    logic [7:0]        wr_data;
    logic [7:0]        rd_data;
    logic              ready;

    modport master (
        output cs, addr, rd_req, wr_en, wr_data,
        input  rd_data, ready
    );

    modport slave (
        input  cs, addr, rd_req, wr_en, wr_data,
        output rd_data, ready
    );
endinterface

// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: turns single-byte CPU requests into timed
// ce_n/oe_n/we_n strobe sequences, stalling the CPU with ready while busy.
`timescale 1ns/1ps
module sram_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int RD_WAIT = 3,
    parameter int WR_WAIT = 2
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    sram_ctrl_if.slave        bus,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dq_out,
    input  logic [7:0]        sram_dq_in,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_ACT,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [7:0]        dq_out_nx, rd_data_nx;
    logic              dq_oe_nx, ce_n_nx, oe_n_nx, we_n_nx, ready_nx;

    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        addr_nx    = sram_addr;
        dq_out_nx  = sram_dq_out;
        rd_data_nx = bus.rd_data;
        dq_oe_nx   = sram_dq_oe;
        ce_n_nx    = sram_ce_n;
        oe_n_nx    = sram_oe_n;
        we_n_nx    = sram_we_n;
        ready_nx   = bus.ready;

        case (state)
            IDLE: begin
                // A write wins over a simultaneous read; the read is dropped.
                if (bus.cs && bus.wr_en) begin
                    addr_nx   = bus.addr;
                    dq_out_nx = bus.wr_data;
                    ce_n_nx   = 1'b0;
                    dq_oe_nx  = 1'b1;
                    ready_nx  = 1'b0;
                    state_nx  = WR_SETUP;
                end else if (bus.cs && bus.rd_req) begin
                    addr_nx  = bus.addr;
                    ce_n_nx  = 1'b0;
                    oe_n_nx  = 1'b0;
                    ready_nx = 1'b0;
                    cnt_nx   = RD_LOAD;
                    state_nx = RD_ACT;
                end
            end
            RD_ACT: begin
                if (cnt == '0) begin
                    rd_data_nx = sram_dq_in;
                    ce_n_nx    = 1'b1;
                    oe_n_nx    = 1'b1;
                    ready_nx   = 1'b1;
                    state_nx   = IDLE;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            WR_SETUP: begin
                we_n_nx  = 1'b0;
                cnt_nx   = WR_LOAD;
                state_nx = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt == '0) begin
                    we_n_nx  = 1'b1;
                    state_nx = WR_HOLD;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            WR_HOLD: begin
                ce_n_nx  = 1'b1;
                dq_oe_nx = 1'b0;
                ready_nx = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            bus.rd_data <= '0;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            bus.ready   <= 1'b1;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            sram_addr   <= addr_nx;
            sram_dq_out <= dq_out_nx;
            bus.rd_data <= rd_data_nx;
            sram_dq_oe  <= dq_oe_nx;
            sram_ce_n   <= ce_n_nx;
            sram_oe_n   <= oe_n_nx;
            sram_we_n   <= we_n_nx;
            bus.ready   <= ready_nx;
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: behavioural SRAM, strobe-timing measurement,
// a read-data scoreboard and per-cycle pin invariants.
`timescale 1ns/1ps
module tb_sram_ctrl;

    logic        sys_clk = 1'b0;
    logic        reset_n;
    logic [15:0] sram_addr;
    logic [7:0]  sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mem [0:65535];
    bit         preloaded;
    bit         mon_en;
    logic       edge_ok;
    logic [15:0] prev_addr;

    sram_ctrl_if #(.ADDR_W(16)) bus ();

    sram_ctrl #(.ADDR_W(16), .RD_WAIT(3), .WR_WAIT(2)) dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n)
    );

    always #5 sys_clk = ~sys_clk;

    // Behavioural SRAM: drives data while oe_n is low, stores while we_n is low.
    assign sram_dq_in = (!sram_oe_n && !sram_ce_n) ? mem[sram_addr] : 8'h00;

    always @(posedge sys_clk) begin
        if (!preloaded) begin
            mem[16'h1234] <= 8'hA5;
            preloaded     <= 1'b1;
        end else if (!sram_ce_n && !sram_we_n) begin
            mem[sram_addr] <= sram_dq_out;
        end
    end

    // sram_addr may only move across an edge where the controller was idle or in reset.
    always @(posedge sys_clk) edge_ok <= bus.ready || !reset_n;

    always @(negedge sys_clk) begin
        if (mon_en) begin
            if (!sram_oe_n && !sram_we_n) $display("FAIL inv_oe_we_overlap: oe_n=%b we_n=%b, required not both 0", sram_oe_n, sram_we_n);
            else n_pass++;
            n_total++;
            if (sram_dq_oe && !sram_oe_n) $display("FAIL inv_dq_oe_vs_oe_n: dq_oe=%b oe_n=%b, required not 1/0", sram_dq_oe, sram_oe_n);
            else n_pass++;
            n_total++;
            if (sram_addr !== prev_addr && !edge_ok) $display("FAIL inv_addr_stable: addr %h -> %h outside acceptance", prev_addr, sram_addr);
            else n_pass++;
            n_total++;
        end
        prev_addr <= sram_addr;
    end

    task automatic issue(input bit rd, input bit wr, input logic [15:0] a, input logic [7:0] d);
        bus.cs      = 1'b1;
        bus.addr    = a;
        bus.rd_req  = rd;
        bus.wr_en   = wr;
        bus.wr_data = d;
    endtask

    // Measures one cycle after a request was driven; returns at the negedge where ready=1.
    task automatic run_cycle(input bit poke, input logic [7:0] exp_d,
                             output int rl, output int cl, output int ol, output int wl,
                             output int dl, output int we_first, output int dq_bad, output bit to);
        logic r;
        rl = 0; cl = 0; ol = 0; wl = 0; dl = 0; we_first = 0; dq_bad = 0; to = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge sys_clk);
            r = bus.ready;
            if (!r) begin
                rl++;
                if (!sram_ce_n) cl++;
                if (!sram_oe_n) ol++;
                if (!sram_we_n) begin
                    wl++;
                    if (we_first == 0) we_first = i;
                end
                if (sram_dq_oe) begin
                    dl++;
                    if (sram_dq_out !== exp_d) dq_bad++;
                end
            end
            bus.rd_req = 1'b0;
            bus.wr_en  = 1'b0;
            if (i == 1 && poke) begin
                bus.rd_req = 1'b1;
                bus.addr   = 16'h0BAD;
            end
            if (r) begin
                to = 1'b0;
                break;
            end
        end
        if (to) $display("FAIL cycle_timeout: ready stayed low for 20 cycles, required to return");
        else n_pass++;
        n_total++;
    endtask

    task automatic check_read_result(input string name);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            $display("FAIL %s_scoreboard: no expected read data queued", name);
            n_total++;
        end else begin
            e = exp_q.pop_front();
            if (bus.rd_data !== e) $display("FAIL %s_rd_data: got %h, required %h", name, bus.rd_data, e);
            else n_pass++;
            n_total++;
        end
    endtask

    task automatic test_reset();
        bus.cs = 1'b0; bus.addr = '0; bus.rd_req = 1'b0; bus.wr_en = 1'b0; bus.wr_data = '0;
        reset_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        if (bus.ready !== 1'b1) $display("FAIL reset_ready: got %b, required 1", bus.ready); else n_pass++;
        n_total++;
        if (bus.rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h, required 00", bus.rd_data); else n_pass++;
        n_total++;
        if (sram_addr !== 16'h0000) $display("FAIL reset_addr: got %h, required 0000", sram_addr); else n_pass++;
        n_total++;
        if (sram_dq_out !== 8'h00 || sram_dq_oe !== 1'b0) $display("FAIL reset_dq: out=%h oe=%b, required 00/0", sram_dq_out, sram_dq_oe); else n_pass++;
        n_total++;
        if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) $display("FAIL reset_strobes: got %b, required 111", {sram_ce_n, sram_oe_n, sram_we_n}); else n_pass++;
        n_total++;
        reset_n = 1'b1;
        @(negedge sys_clk);
        mon_en = 1'b1;
    endtask

    task automatic test_read();
        int rl, cl, ol, wl, dl, wf, db; bit to;
        issue(1'b1, 1'b0, 16'h1234, 8'h00);
        exp_q.push_back(8'hA5);
        run_cycle(1'b0, 8'h00, rl, cl, ol, wl, dl, wf, db, to);
        if (rl != 3) $display("FAIL read_ready_low: got %0d cycles, required 3", rl); else n_pass++;
        n_total++;
        if (cl != 3 || ol != 3) $display("FAIL read_strobes: ce_n low %0d oe_n low %0d, required 3/3", cl, ol); else n_pass++;
        n_total++;
        if (wl != 0 || dl != 0) $display("FAIL read_no_write: we_n low %0d dq_oe %0d, required 0/0", wl, dl); else n_pass++;
        n_total++;
        if (sram_addr !== 16'h1234) $display("FAIL read_addr: got %h, required 1234", sram_addr); else n_pass++;
        n_total++;
        check_read_result("read");
    endtask

    task automatic test_write();
        int rl, cl, ol, wl, dl, wf, db; bit to;
        issue(1'b0, 1'b1, 16'h8000, 8'h5A);
        run_cycle(1'b0, 8'h5A, rl, cl, ol, wl, dl, wf, db, to);
        if (wl != 2) $display("FAIL write_we_low: got %0d cycles, required 2", wl); else n_pass++;
        n_total++;
        if (wf != 2) $display("FAIL write_setup: we_n fell in cycle %0d, required 2", wf); else n_pass++;
        n_total++;
        if (dl != 4 || db != 0) $display("FAIL write_dq: dq_oe %0d cycles, %0d bad, required 4/0", dl, db); else n_pass++;
        n_total++;
        if (rl != 4 || cl != 4 || ol != 0) $display("FAIL write_ready_low: ready %0d ce %0d oe %0d, required 4/4/0", rl, cl, ol); else n_pass++;
        n_total++;
        if (sram_addr !== 16'h8000 || mem[16'h8000] !== 8'h5A) $display("FAIL write_mem: addr %h mem %h, required 8000/5A", sram_addr, mem[16'h8000]); else n_pass++;
        n_total++;
    endtask

    task automatic test_back_to_back();
        int rl, cl, ol, wl, dl, wf, db; bit to;
        issue(1'b0, 1'b1, 16'h0010, 8'h11);
        run_cycle(1'b0, 8'h11, rl, cl, ol, wl, dl, wf, db, to);
        issue(1'b1, 1'b0, 16'h0010, 8'h00);
        exp_q.push_back(8'h11);
        if (sram_dq_oe !== 1'b0 || sram_oe_n !== 1'b1) $display("FAIL b2b_turnaround: dq_oe=%b oe_n=%b, required 0/1", sram_dq_oe, sram_oe_n); else n_pass++;
        n_total++;
        @(negedge sys_clk);
        bus.rd_req = 1'b0;
        if (bus.ready !== 1'b0 || sram_oe_n !== 1'b0) $display("FAIL b2b_immediate: ready=%b oe_n=%b, required 0/0", bus.ready, sram_oe_n); else n_pass++;
        n_total++;
        run_cycle(1'b0, 8'h00, rl, cl, ol, wl, dl, wf, db, to);
        if (rl != 2) $display("FAIL b2b_read_len: got %0d more busy cycles, required 2", rl); else n_pass++;
        n_total++;
        check_read_result("b2b");
    endtask

    task automatic test_ignored();
        int rl, cl, ol, wl, dl, wf, db; bit to;
        bus.cs = 1'b0; bus.addr = 16'h1234; bus.rd_req = 1'b1;
        @(negedge sys_clk);
        bus.rd_req = 1'b0;
        if (bus.ready !== 1'b1 || sram_ce_n !== 1'b1 || sram_oe_n !== 1'b1) $display("FAIL nocs_strobes: ready=%b ce_n=%b oe_n=%b, required 1/1/1", bus.ready, sram_ce_n, sram_oe_n); else n_pass++;
        n_total++;
        if (bus.rd_data !== 8'h11 || sram_addr !== 16'h0010) $display("FAIL nocs_hold: rd_data=%h addr=%h, required 11/0010", bus.rd_data, sram_addr); else n_pass++;
        n_total++;
        issue(1'b1, 1'b0, 16'h8000, 8'h00);
        exp_q.push_back(8'h5A);
        run_cycle(1'b1, 8'h00, rl, cl, ol, wl, dl, wf, db, to);
        if (rl != 3 || sram_addr !== 16'h8000) $display("FAIL busy_ignored: ready low %0d addr %h, required 3/8000", rl, sram_addr); else n_pass++;
        n_total++;
        check_read_result("busy");
        @(negedge sys_clk);
        bus.rd_req = 1'b0;
        if (bus.ready !== 1'b1 || sram_oe_n !== 1'b1) $display("FAIL busy_no_retry: ready=%b oe_n=%b, required 1/1", bus.ready, sram_oe_n); else n_pass++;
        n_total++;
    endtask

    task automatic test_rd_wr_both();
        int rl, cl, ol, wl, dl, wf, db; bit to;
        issue(1'b1, 1'b1, 16'h0200, 8'h77);
        run_cycle(1'b0, 8'h77, rl, cl, ol, wl, dl, wf, db, to);
        if (wl != 2 || ol != 0 || rl != 4) $display("FAIL both_write_only: we %0d oe %0d ready %0d, required 2/0/4", wl, ol, rl); else n_pass++;
        n_total++;
        if (bus.rd_data !== 8'h5A) $display("FAIL both_rd_data: got %h, required 5A", bus.rd_data); else n_pass++;
        n_total++;
        issue(1'b1, 1'b0, 16'h0200, 8'h00);
        exp_q.push_back(8'h77);
        run_cycle(1'b0, 8'h00, rl, cl, ol, wl, dl, wf, db, to);
        check_read_result("both_readback");
    endtask

    task automatic test_reset_mid_write();
        int rl, cl, ol, wl, dl, wf, db; bit to;
        issue(1'b0, 1'b1, 16'h0300, 8'h33);
        @(negedge sys_clk);
        bus.wr_en = 1'b0;
        @(negedge sys_clk);
        if (sram_we_n !== 1'b0) $display("FAIL rst_pre_pulse: we_n=%b, required 0", sram_we_n); else n_pass++;
        n_total++;
        reset_n = 1'b0;
        @(negedge sys_clk);
        if ({sram_we_n, sram_ce_n, sram_oe_n} !== 3'b111 || sram_dq_oe !== 1'b0) $display("FAIL rst_abort_strobes: we/ce/oe=%b dq_oe=%b, required 111/0", {sram_we_n, sram_ce_n, sram_oe_n}, sram_dq_oe); else n_pass++;
        n_total++;
        if (bus.ready !== 1'b1 || bus.rd_data !== 8'h00) $display("FAIL rst_abort_state: ready=%b rd_data=%h, required 1/00", bus.ready, bus.rd_data); else n_pass++;
        n_total++;
        reset_n = 1'b1;
        @(negedge sys_clk);
        issue(1'b1, 1'b0, 16'h1234, 8'h00);
        exp_q.push_back(8'hA5);
        run_cycle(1'b0, 8'h00, rl, cl, ol, wl, dl, wf, db, to);
        if (rl != 3) $display("FAIL rst_recover_len: got %0d, required 3", rl); else n_pass++;
        n_total++;
        check_read_result("rst_recover");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        mon_en = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_ignored();
        test_rd_wr_both();
        test_reset_mid_write();
        repeat (2) @(negedge sys_clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
